gsim_residual: RTL and testbench
================================

Name: gsim_residual

Overview:
- Downstream checker for the GSIM Gauss-Seidel solver. It captures the same 16-entry b vector that GSIM receives, then consumes GSIM's x_out/out_valid stream.
- For each row it computes the residual r[i] = b[i] - (A·x)[i] on the fixed 7-band matrix (-1, 6, -13, 20, -13, 6, -1), entirely in hardware.
- It reports per-row residuals, the maximum magnitude and a convergence flag, replacing the software error check in silicon bring-up.

Parameters:
- N, 16, vector length (rows); fixed-band logic supports N >= 7
- TOL, 32'h0000_0100, convergence threshold on max |r|, Q16.16 (1/256)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- b_en  in  1  b_in valid strobe, one element per cycle
- b_in  in  16  b element, signed integer, row order 0..N-1
- x_valid  in  1  connect to GSIM out_valid
- x_in  in  32  x element, signed Q16.16, row order 0..N-1
- r_valid  out  1  r_out/r_idx valid, one-cycle pulse per row
- r_idx  out  4  row index of r_out
- r_out  out  32  residual, signed Q16.16, saturated
- done  out  1  one-cycle pulse after row N-1 emitted
- max_abs  out  32  max |r_out| over the vector, unsigned Q16.16, valid when done=1
- converged  out  1  (max_abs <= TOL), valid when done=1
- sq_err  out  64  see Optional Feature

Behaviour:
- Reset: all outputs 0; counters 0; window cleared; state LOAD_B. b_mem is not reset.
- Reset asserted mid-operation: the block aborts immediately and returns to LOAD_B; no r_valid or done follows.
- LOAD_B: each b_en writes b_mem[b_cnt] and increments b_cnt.
  - After element N-1 the state moves to RUN.
  - x_valid is ignored in LOAD_B.
- RUN: each x_valid shifts x_in into a 7-entry window.
  - The window is zero-filled for indices < 0 at vector start.
  - b_en is ignored in RUN and FLUSH.
  - When x[k] is accepted with k >= 3, row k-3 is computed. r_valid=1 and r_idx=k-3 appear the next cycle, registered (latency 1).
  - After x[N-1] the state moves to FLUSH.
- FLUSH: 3 consecutive cycles emit rows N-3, N-2, N-1, shifting zeros in for indices >= N. x_valid is ignored. Then the state moves to DONE.
- DONE: single cycle.
  - done=1; max_abs and converged are registered and held until the next DONE or reset.
  - Counters clear and the state returns to LOAD_B.
  - A new b vector may start on the cycle after done.
- Arithmetic: constant multiplies use shift-add only (20x=16x+4x, 13x=8x+4x+x, 6x=4x+2x).
  - Accumulate in 38-bit signed.
  - b is sign-extended and shifted left by 16 to 38 bits.
  - r = b<<16 - sum.
  - Saturate to 32 bits: 0x7FFF_FFFF / 0x8000_0000.
  - |r| of 0x8000_0000 is 0x8000_0000 as unsigned.
- max_abs: running max of |r_out|; it resets to 0 at the start of each vector.
- Gaps between x_valid pulses are allowed; the row output waits for the next x.

Optional Feature:
- Macro: GSIM_RES_SQERR_EN.
- When defined: sq_err accumulates r_out^2 (64-bit unsigned Q32.32) over the vector, saturating at 0xFFFF_FFFF_FFFF_FFFF. It is registered at done and held.
  - The squarer is pipelined by one stage; the accumulation of the final row completes before done.
  - done stays 1 cycle after the last r_valid, so the FLUSH-to-DONE timing is unchanged.
- When undefined: no multiplier is built and sq_err is tied to 0.

Test Plan:
- Zero vectors: b=0 and x=0 for all 16 rows -> 16 r_valid pulses with r_idx 0..15 and r_out=0; then done with max_abs=0, converged=1, sq_err=0.
- Unit column: x[0]=0x0001_0000, others 0; b=[20,-13,6,-1,0...] -> all r_out=0 and converged=1. Changing b[0] to 21 instead gives r_out[0]=0x0001_0000, max_abs=0x0001_0000, converged=0, sq_err=0x1_0000_0000 (with GSIM_RES_SQERR_EN).
- Single b: x=0 and b[5]=-3, others 0 -> r_out[5]=0xFFFD_0000, others 0, max_abs=0x0003_0000, converged=0.
- Saturation: b[i]=32767 and x[i]=0x8000_0000 for all i -> r_out[0]=0x7FFF_FFFF, max_abs=0x7FFF_FFFF.
- Protocol: x_valid pulses during LOAD_B and b_en pulses during RUN are ignored. With 5 idle cycles between x pulses, each r_valid arrives exactly 1 cycle after the enabling x, and the flush rows follow back-to-back.
- Reset: assert reset low after x[8] -> all outputs 0 at once, no done. Then a full clean vector completes normally with the correct residuals.

Source files
------------

// File: rtl/gsim_residual.sv
// gsim_residual: residual checker for the GSIM Gauss-Seidel output stream, r[i] = b[i] - (A*x)[i], A = band(-1,6,-13,20,-13,6,-1).
// Latency: row i is emitted 1 cycle after x[i+3] is accepted; the last three rows flush back-to-back, done follows 1 cycle later.
// No backpressure: b_en/x_valid are accepted whenever the state allows. GSIM_RES_SQERR_EN adds a squared-error accumulator.
module gsim_residual #(
  parameter int          N   = 16,
  parameter logic [31:0] TOL = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 b_en,
  input  logic [15:0]          b_in,
  input  logic                 x_valid,
  input  logic [31:0]          x_in,
  output logic                 r_valid,
  output logic [$clog2(N)-1:0] r_idx,
  output logic [31:0]          r_out,
  output logic                 done,
  output logic [31:0]          max_abs,
  output logic                 converged,
  output logic [63:0]          sq_err
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {LOAD_B, RUN, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] b_cnt_q, b_cnt_d;
  logic [IW-1:0] x_cnt_q, x_cnt_d;
  logic [1:0]    fl_cnt_q, fl_cnt_d;
  logic [31:0]   win_q [7];
  logic [31:0]   win_d [7];
  logic [15:0]   b_mem_q [N];
  logic [15:0]   b_mem_d [N];
  logic          do_row;
  logic [IW-1:0] row_idx;

  // Sequencing: b capture, x window shift (win[0] newest), zero-fed flush of the last three rows
  always_comb begin
    state_d  = state_q;
    b_cnt_d  = b_cnt_q;
    x_cnt_d  = x_cnt_q;
    fl_cnt_d = fl_cnt_q;
    win_d    = win_q;
    b_mem_d  = b_mem_q;
    do_row   = 1'b0;
    row_idx  = '0;
    case (state_q)
      LOAD_B: begin
        if (b_en) begin
          b_mem_d[b_cnt_q] = b_in;
          b_cnt_d = b_cnt_q + IW'(1);
          if (b_cnt_q == IW'(N - 1)) begin
            b_cnt_d = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (x_valid) begin
          win_d[0] = x_in;
          for (int i = 1; i < 7; i++) win_d[i] = win_q[i-1];
          x_cnt_d = x_cnt_q + IW'(1);
          // The window is centred on x[k-3] once x[k] arrives
          if (x_cnt_q >= IW'(3)) begin
            do_row  = 1'b1;
            row_idx = x_cnt_q - IW'(3);
          end
          if (x_cnt_q == IW'(N - 1)) begin
            x_cnt_d = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        win_d[0] = '0;
        for (int i = 1; i < 7; i++) win_d[i] = win_q[i-1];
        do_row   = 1'b1;
        row_idx  = IW'(N - 3) + IW'(fl_cnt_q);
        fl_cnt_d = fl_cnt_q + 2'd1;
        if (fl_cnt_q == 2'd2) begin
          fl_cnt_d = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        for (int i = 0; i < 7; i++) win_d[i] = '0;
        b_cnt_d  = '0;
        x_cnt_d  = '0;
        fl_cnt_d = '0;
        state_d  = LOAD_B;
      end
      default: state_d = LOAD_B;
    endcase
  end

  logic signed [37:0] w [7];
  logic signed [37:0] p06, p15, p24, ax, b_sh, r_full;
  logic [15:0]        b_row;
  logic [31:0]        r_sat, r_abs;

  // Band dot product by shift-add on the updated window, then b<<16 minus it, saturated to 32 bits
  always_comb begin
    for (int i = 0; i < 7; i++) w[i] = {{6{win_d[i][31]}}, win_d[i]};
    b_row  = b_mem_q[row_idx];
    p06    = w[0] + w[6];
    p15    = w[1] + w[5];
    p24    = w[2] + w[4];
    ax     = (w[3] <<< 4) + (w[3] <<< 2) + (p15 <<< 2) + (p15 <<< 1)
           - (p24 <<< 3) - (p24 <<< 2) - p24 - p06;
    b_sh   = {{6{b_row[15]}}, b_row, 16'h0000};
    r_full = b_sh - ax;
    r_sat  = r_full[31:0];
    if (!r_full[37] && (r_full[36:31] != 6'h00)) r_sat = 32'h7FFF_FFFF;
    else if (r_full[37] && (r_full[36:31] != 6'h3F)) r_sat = 32'h8000_0000;
    // 0x8000_0000 negates to itself, which reads correctly as unsigned
    r_abs  = r_sat[31] ? (~r_sat + 32'd1) : r_sat;
  end

  logic          r_valid_q, r_valid_d, done_q, done_d, conv_q, conv_d;
  logic [IW-1:0] r_idx_q, r_idx_d;
  logic [31:0]   r_out_q, r_out_d, max_q, max_d, run_max_q, run_max_d;

  // Row outputs, running max (cleared at DONE for the next vector) and held end-of-vector summary
  always_comb begin
    r_valid_d = do_row;
    r_idx_d   = r_idx_q;
    r_out_d   = r_out_q;
    run_max_d = run_max_q;
    done_d    = 1'b0;
    max_d     = max_q;
    conv_d    = conv_q;
    if (do_row) begin
      r_idx_d = row_idx;
      r_out_d = r_sat;
      if (r_abs > run_max_q) run_max_d = r_abs;
    end
    if (state_q == DONE) begin
      done_d    = 1'b1;
      max_d     = run_max_q;
      conv_d    = (run_max_q <= TOL);
      run_max_d = '0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD_B;
      b_cnt_q   <= '0;
      x_cnt_q   <= '0;
      fl_cnt_q  <= '0;
      win_q     <= '{default: '0};
      r_valid_q <= 1'b0;
      r_idx_q   <= '0;
      r_out_q   <= '0;
      run_max_q <= '0;
      done_q    <= 1'b0;
      max_q     <= '0;
      conv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_cnt_q   <= b_cnt_d;
      x_cnt_q   <= x_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      win_q     <= win_d;
      r_valid_q <= r_valid_d;
      r_idx_q   <= r_idx_d;
      r_out_q   <= r_out_d;
      run_max_q <= run_max_d;
      done_q    <= done_d;
      max_q     <= max_d;
      conv_q    <= conv_d;
    end
  end

  // b storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    b_mem_q <= b_mem_d;
  end

`ifdef GSIM_RES_SQERR_EN
  logic signed [63:0] r_ext;
  logic [63:0]        sq_prod, sq_acc_q, sq_acc_d, sq_err_q, sq_err_d;
  logic [64:0]        sq_sum;

  // Square the registered row output; the final row lands in the DONE cycle, alongside the summary
  always_comb begin
    r_ext    = {{32{r_out_q[31]}}, r_out_q};
    sq_prod  = r_valid_q ? 64'(r_ext * r_ext) : 64'h0;
    sq_sum   = {1'b0, sq_acc_q} + {1'b0, sq_prod};
    sq_acc_d = sq_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sq_sum[63:0];
    sq_err_d = sq_err_q;
    if (state_q == DONE) begin
      sq_err_d = sq_acc_d;
      sq_acc_d = '0;
    end
  end

  // Squared-error accumulator and held result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_acc_q <= '0;
      sq_err_q <= '0;
    end else begin
      sq_acc_q <= sq_acc_d;
      sq_err_q <= sq_err_d;
    end
  end

  assign sq_err = sq_err_q;
`else
  assign sq_err = 64'h0;
`endif

  assign r_valid   = r_valid_q;
  assign r_idx     = r_idx_q;
  assign r_out     = r_out_q;
  assign done      = done_q;
  assign max_abs   = max_q;
  assign converged = conv_q;

endmodule

// File: tb/tb_gsim_residual.sv
// tb_gsim_residual: directed vectors for gsim_residual with a queue-based scoreboard.
// The driver pushes expected rows/summaries; a negedge monitor pops and compares on r_valid/done.
// Protocol timing (latency, gap quiet, back-to-back flush, done pulse) is checked inline by the driver.
module tb_gsim_residual;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        b_en = 1'b0;
  logic [15:0] b_in = '0;
  logic        x_valid = 1'b0;
  logic [31:0] x_in = '0;
  logic        r_valid;
  logic [3:0]  r_idx;
  logic [31:0] r_out;
  logic        done;
  logic [31:0] max_abs;
  logic        converged;
  logic [63:0] sq_err;

  always #5 clk = ~clk;

  gsim_residual #(.N(N), .TOL(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .b_en(b_en), .b_in(b_in), .x_valid(x_valid), .x_in(x_in),
    .r_valid(r_valid), .r_idx(r_idx), .r_out(r_out), .done(done),
    .max_abs(max_abs), .converged(converged), .sq_err(sq_err)
  );

  typedef struct { logic [3:0] idx; logic [31:0] val; } row_t;
  typedef struct { logic [31:0] mx; logic conv; logic [63:0] sq; } fin_t;

  row_t row_q[$];
  fin_t fin_q[$];
  row_t mon_row;
  fin_t mon_fin;
  int   n_vec = 0;
  int   n_bad = 0;

  logic signed [15:0] bvec [N];
  logic [31:0]        xvec [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference residual with plain integer multiplies over the full band
  function automatic logic [31:0] model_row(input int i);
    int     c[7];
    longint s, r;
    c = '{-1, 6, -13, 20, -13, 6, -1};
    s = 0;
    for (int m = -3; m <= 3; m++)
      if (i + m >= 0 && i + m < N) s += longint'(c[m+3]) * longint'($signed(xvec[i+m]));
    r = longint'(bvec[i]) * 65536 - s;
    if (r > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (r < -64'sh8000_0000) return 32'h8000_0000;
    return r[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    b_en    = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_r_valid"}, 64'(r_valid), 64'h0);
    chk({pfx, "_r_idx"}, 64'(r_idx), 64'h0);
    chk({pfx, "_r_out"}, 64'(r_out), 64'h0);
    chk({pfx, "_done"}, 64'(done), 64'h0);
    chk({pfx, "_max_abs"}, 64'(max_abs), 64'h0);
    chk({pfx, "_converged"}, 64'(converged), 64'h0);
    chk({pfx, "_sq_err"}, sq_err, 64'h0);
  endtask

  task automatic clear_vec();
    for (int i = 0; i < N; i++) begin
      bvec[i] = '0;
      xvec[i] = '0;
    end
  endtask

  // One full vector: b load, x stream, flush and done; exp_max/exp_conv are hand-computed per test
  task automatic run_vector(input logic [31:0] exp_max, input logic exp_conv, input int gap,
                            input bit noise, input int abort_at);
    fin_t        f;
    row_t        e;
    logic [64:0] acc;
    longint      rr;
    bit          aborted;
    acc = '0;
    aborted = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.idx = 4'(i);
      e.val = model_row(i);
      row_q.push_back(e);
      rr  = longint'($signed(e.val));
      acc = acc + {1'b0, 64'(rr * rr)};
      if (acc[64]) acc = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    end
    f.mx   = exp_max;
    f.conv = exp_conv;
`ifdef GSIM_RES_SQERR_EN
    f.sq   = acc[63:0];
`else
    f.sq   = 64'h0;
`endif
    if (abort_at < 0) fin_q.push_back(f);

    for (int i = 0; i < N; i++) begin
      if (noise) begin x_valid = 1'b1; x_in = $urandom; step(); end
      b_en = 1'b1; b_in = bvec[i]; step();
    end

    for (int k = 0; k < N; k++) begin
      if (noise && (k % 4 == 1)) begin b_en = 1'b1; b_in = 16'h7777; step(); end
      x_valid = 1'b1; x_in = xvec[k]; step();
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check_idle("abort");
        row_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) step();
        chk("abort_no_done", 64'(done), 64'h0);
        aborted = 1'b1;
        break;
      end
      if (gap > 0 && k < N - 1) begin
        if (k >= 3) begin
          chk($sformatf("lat_vld_k%0d", k), 64'(r_valid), 64'h1);
          chk($sformatf("lat_idx_k%0d", k), 64'(r_idx), 64'(k - 3));
        end
        step();
        chk($sformatf("gap_quiet_k%0d", k), 64'(r_valid), 64'h0);
        for (int g = 1; g < gap; g++) step();
      end
    end

    if (!aborted) begin
      chk("flush_vld0", 64'(r_valid), 64'h1);
      chk("flush_idx0", 64'(r_idx), 64'(N - 4));
      for (int j = 1; j <= 3; j++) begin
        if (noise) begin b_en = 1'b1; b_in = 16'h5A5A; end
        step();
        chk($sformatf("flush_vld%0d", j), 64'(r_valid), 64'h1);
        chk($sformatf("flush_idx%0d", j), 64'(r_idx), 64'(N - 4 + j));
      end
      step();
      chk("done_pulse", 64'(done), 64'h1);
      chk("done_row_quiet", 64'(r_valid), 64'h0);
    end
  endtask

  // Scoreboard monitor: compare every emitted row and every done summary
  always @(negedge clk) begin
    if (reset) begin
      if (r_valid) begin
        if (row_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_row: r_idx %0d r_out 0x%h, expected no row", r_idx, r_out);
        end else begin
          mon_row = row_q.pop_front();
          chk($sformatf("r_idx_row%0d", mon_row.idx), 64'(r_idx), 64'(mon_row.idx));
          chk($sformatf("r_out_row%0d", mon_row.idx), 64'(r_out), 64'(mon_row.val));
        end
      end
      if (done) begin
        if (fin_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_done: max_abs 0x%h, expected no done", max_abs);
        end else begin
          mon_fin = fin_q.pop_front();
          chk("max_abs", 64'(max_abs), 64'(mon_fin.mx));
          chk("converged", 64'(converged), 64'(mon_fin.conv));
          chk("sq_err", sq_err, mon_fin.sq);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b1;

    // Zero vectors: all rows 0, max 0, converged
    clear_vec();
    run_vector(32'h0, 1'b1, 0, 1'b0, -1);

    // Unit column: b matches column 0 of A, all rows 0
    clear_vec();
    xvec[0] = 32'h0001_0000;
    bvec[0] = 16'sd20; bvec[1] = -16'sd13; bvec[2] = 16'sd6; bvec[3] = -16'sd1;
    run_vector(32'h0, 1'b1, 0, 1'b0, -1);

    // Same with b[0]=21: r[0]=1.0
    bvec[0] = 16'sd21;
    run_vector(32'h0001_0000, 1'b0, 0, 1'b0, -1);

    // Single b: b[5]=-3, x=0 -> r[5]=0xFFFD_0000
    clear_vec();
    bvec[5] = -16'sd3;
    run_vector(32'h0003_0000, 1'b0, 0, 1'b0, -1);

    // Saturation: b=32767, x=-32768.0 everywhere
    for (int i = 0; i < N; i++) begin bvec[i] = 16'sh7FFF; xvec[i] = 32'h8000_0000; end
    run_vector(32'h7FFF_FFFF, 1'b0, 0, 1'b0, -1);

    // Max exactly TOL: x[6]=8, x[7]=18 raw gives r[7]=-256, others smaller
    clear_vec();
    xvec[6] = 32'd8; xvec[7] = 32'd18;
    run_vector(32'h0000_0100, 1'b1, 0, 1'b0, -1);

    // Just over TOL: x[0]=13 raw gives r[0]=-260
    clear_vec();
    xvec[0] = 32'd13;
    run_vector(32'h0000_0104, 1'b0, 0, 1'b0, -1);

    // Protocol: stray x in LOAD_B, stray b_en in RUN/FLUSH, 5 idle cycles between x
    clear_vec();
    xvec[0] = 32'h0001_0000;
    bvec[0] = 16'sd21; bvec[1] = -16'sd13; bvec[2] = 16'sd6; bvec[3] = -16'sd1;
    run_vector(32'h0001_0000, 1'b0, 5, 1'b1, -1);

    // Reset after x[8], then a clean vector
    clear_vec();
    bvec[5] = -16'sd3;
    run_vector(32'h0, 1'b0, 0, 1'b0, 8);

    // x=1.0, b=4 everywhere: interior rows 0, edges -8, 5, -1
    for (int i = 0; i < N; i++) begin bvec[i] = 16'sd4; xvec[i] = 32'h0001_0000; end
    run_vector(32'h0008_0000, 1'b0, 0, 1'b0, -1);

    repeat (4) step();
    chk("rows_outstanding", 64'(row_q.size()), 64'h0);
    chk("done_outstanding", 64'(fin_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
